// File: rtl/sn_cdir_scan_ctrl.sv
// CDIR odometer scan sequencer: clears, measures and captures each RO sensor pair, then reports avg/max aging.
// Optional macro CDIR_SCAN_TIMEOUT_EN bounds the wait for valid_in to TIMEOUT_CYCLES and flags timeout_err.
module sn_cdir_scan_ctrl #(
    parameter int unsigned NO_CDIR        = 8,
    parameter int unsigned MUX_SEL_SIZE   = $clog2(NO_CDIR),
    parameter int unsigned CLR_CYCLES     = 4,
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter logic [31:0] AGE_THRESH     = 32'd16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [1:0]              mode,
    output logic [MUX_SEL_SIZE-1:0] r_mux_sel,
    output logic [MUX_SEL_SIZE-1:0] s_mux_sel,
    input  logic [31:0]             r_freq,
    input  logic [31:0]             s_freq,
    input  logic                    valid_in,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             avg_diff,
    output logic [31:0]             max_diff,
    output logic [MUX_SEL_SIZE-1:0] max_idx,
    output logic                    aged,
    output logic                    underflow,
    output logic                    timeout_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLR    = 3'd1;
    localparam logic [2:0] MEAS   = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] CAPT   = 3'd4;
    localparam logic [2:0] NEXT   = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam int unsigned CNT_MAX_A = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned ACC_W     = 32 + MUX_SEL_SIZE;

    logic [2:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [MUX_SEL_SIZE-1:0] r_idx;
    logic [ACC_W-1:0]        r_acc;
    logic [31:0]             r_run_max;
    logic [MUX_SEL_SIZE-1:0] r_run_idx;
    logic [1:0]              r_mode;
    logic                    r_busy;
    logic                    r_done;
    logic [31:0]             r_avg;
    logic [31:0]             r_max_diff;
    logic [MUX_SEL_SIZE-1:0] r_max_idx;
    logic                    r_aged;
    logic                    r_underflow;
    logic                    r_timeout;

    logic [2:0]  w_next;
    logic [1:0]  w_mode;
    logic        w_under;
    logic [31:0] w_diff;
    logic [31:0] w_avg;
    logic        w_last;

    assign w_under = (s_freq > r_freq);
    assign w_diff  = w_under ? '0 : (r_freq - s_freq);
    assign w_avg   = r_acc[ACC_W-1:MUX_SEL_SIZE];
    assign w_last  = (r_idx == MUX_SEL_SIZE'(NO_CDIR - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (start) w_next = CLR;
            CLR:    if (r_cnt == CNT_W'(CLR_CYCLES - 1)) w_next = MEAS;
            MEAS: begin
                if (valid_in) begin
                    w_next = SETTLE;
                end
`ifdef CDIR_SCAN_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_next = NEXT;
                end
`endif
            end
            SETTLE: if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) w_next = CAPT;
            CAPT:   w_next = NEXT;
            NEXT:   w_next = w_last ? DONE : CLR;
            DONE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        w_mode = 2'b01;
        case (w_next)
            CLR, NEXT:          w_mode = 2'b00;
            MEAS, SETTLE, CAPT: w_mode = 2'b10;
            default:            w_mode = 2'b01;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_run_max   <= '0;
            r_run_idx   <= '0;
            r_mode      <= 2'b00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_avg       <= '0;
            r_max_diff  <= '0;
            r_max_idx   <= '0;
            r_aged      <= 1'b0;
            r_underflow <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_mode  <= w_mode;
            r_busy  <= (w_next != IDLE) && (w_next != DONE);
            r_done  <= (w_next == DONE);
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx       <= '0;
                        r_acc       <= '0;
                        r_run_max   <= '0;
                        r_run_idx   <= '0;
                        r_underflow <= 1'b0;
                        r_timeout   <= 1'b0;
                    end
                end
                MEAS: begin
`ifdef CDIR_SCAN_TIMEOUT_EN
                    if (w_next == NEXT) r_timeout <= 1'b1;
`endif
                end
                CAPT: begin
                    r_acc <= r_acc + ACC_W'(w_diff);
                    if (w_under) r_underflow <= 1'b1;
                    if (w_diff > r_run_max) begin
                        r_run_max <= w_diff;
                        r_run_idx <= r_idx;
                    end
                end
                NEXT: begin
                    if (!w_last) begin
                        r_idx <= r_idx + MUX_SEL_SIZE'(1);
                    end else begin
                        r_avg      <= w_avg;
                        r_max_diff <= r_run_max;
                        r_max_idx  <= r_run_idx;
                        r_aged     <= (w_avg >= AGE_THRESH);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mode      = r_mode;
    assign r_mux_sel = r_idx;
    assign s_mux_sel = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign avg_diff  = r_avg;
    assign max_diff  = r_max_diff;
    assign max_idx   = r_max_idx;
    assign aged      = r_aged;
    assign underflow = r_underflow;
`ifdef CDIR_SCAN_TIMEOUT_EN
    assign timeout_err = r_timeout;
`else
    assign timeout_err = 1'b0;
    logic w_timeout_unused;
    assign w_timeout_unused = r_timeout;
`endif

endmodule

// File: doc/sn_cdir_scan_ctrl.md
Name: sn_cdir_scan_ctrl

Overview:
- Measurement sequencer for the RO lifecycle odometer. It is the initiator on the odometer decoder's mode/select/frequency interface.
- On a start request it scans every CDIR sensor pair in turn:
  - clears the decoder counters (mode 00),
  - runs a measurement window (mode 10),
  - captures the reference and stressed frequency counts,
  - accumulates the aging difference (reference minus stressed).
- Between scans it parks the decoder in stress mode (01).
- It reports the average and maximum difference and an aged flag to the security-engine host.

Parameters:
- NO_CDIR, 8, number of RO sensor pairs; must be a power of 2.
- MUX_SEL_SIZE, $clog2(NO_CDIR), width of the sensor select.
- CLR_CYCLES, 4, cycles mode 00 is held before each measurement (minimum 1).
- SETTLE_CYCLES, 8, cycles waited after valid_in before frequency capture. This lets the RO-domain frequency registers settle (minimum 1).
- AGE_THRESH, 32'd16, average difference at or above which aged asserts.
- TIMEOUT_CYCLES, 4096, maximum wait for valid_in (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle scan request; ignored unless busy=0
- mode  out  2  decoder mode: 00 reset, 01 stress, 10 measure
- r_mux_sel  out  MUX_SEL_SIZE  reference RO select
- s_mux_sel  out  MUX_SEL_SIZE  stressed RO select (always equal to r_mux_sel)
- r_freq  in  32  reference count from decoder
- s_freq  in  32  stressed count from decoder
- valid_in  in  1  decoder measurement-complete flag
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan completion
- avg_diff  out  32  mean per-sensor difference of last scan
- max_diff  out  32  largest per-sensor difference of last scan
- max_idx  out  MUX_SEL_SIZE  sensor index of max_diff
- aged  out  1  avg_diff >= AGE_THRESH
- underflow  out  1  sticky per scan; some sensor had s_freq > r_freq
- timeout_err  out  1  sticky per scan; valid_in never arrived

Behaviour:
- Reset (rst=1 at clk edge, including mid-scan):
  - mode=00, selects=0, busy=0, done=0, avg_diff=0, max_diff=0, max_idx=0, aged=0, underflow=0, timeout_err=0.
  - State goes to IDLE and all internal counters and the accumulator are cleared.
- States: IDLE, CLR, MEAS, SETTLE, CAPT, NEXT, DONE. All outputs are registered.
- IDLE:
  - mode=01, busy=0.
  - start=1 -> CLR next cycle with idx=0. At the same time clear the accumulator, running max, max_idx, underflow and timeout_err.
  - Previous result outputs hold until the DONE of the next scan.
- CLR:
  - mode=00, selects=idx, busy=1.
  - Stays exactly CLR_CYCLES cycles, then -> MEAS.
- MEAS:
  - mode=10, selects=idx.
  - Waits for valid_in=1 sampled at clk, then -> SETTLE.
  - valid_in=1 on the first MEAS cycle is accepted.
- SETTLE:
  - mode=10 held for exactly SETTLE_CYCLES cycles, then -> CAPT.
- CAPT (one cycle, mode=10):
  - Sample r_freq and s_freq.
  - diff = r_freq - s_freq if r_freq >= s_freq, else diff=0 and underflow set.
  - Accumulator (32+MUX_SEL_SIZE bits, cannot overflow) += diff.
  - If diff > running max: update max and max_idx=idx. Ties keep the lower index.
- NEXT (mode=00):
  - idx==NO_CDIR-1 -> DONE.
  - Otherwise idx+1 -> CLR. The CLR hold count restarts, so each sensor gets a full CLR_CYCLES.
- DONE (one cycle):
  - avg_diff = accumulator >> MUX_SEL_SIZE (truncating).
  - max_diff and max_idx take the running values; aged = (new avg_diff >= AGE_THRESH).
  - done=1 for this cycle only; mode=01; -> IDLE. busy deasserts in this cycle.
- Latency (no timeout), sensor count N, valid_in arriving L cycles after MEAS entry:
  - start-to-done = 1 + N*(CLR_CYCLES + L + 1 + SETTLE_CYCLES + 1 + 1) cycles.
- start while busy=1 is ignored. start coincident with rst is ignored.
- r_mux_sel and s_mux_sel are always driven identically.

Optional Feature:
- Macro CDIR_SCAN_TIMEOUT_EN.
- Defined:
  - MEAS carries a cycle counter. If valid_in has not been seen after TIMEOUT_CYCLES cycles in MEAS, set timeout_err and skip capture (diff treated as 0) -> NEXT.
  - The scan still completes, and avg_diff divides by NO_CDIR.
- Not defined:
  - MEAS waits indefinitely and timeout_err is tied to 0.

Test Plan:
- NO_CDIR=4, CLR_CYCLES=4, SETTLE_CYCLES=8. Decoder model asserts valid_in 102 cycles after mode=10 with r=100, s=80 for all sensors -> done pulses once; avg_diff=20, max_diff=20, max_idx=0, aged=1 (AGE_THRESH=16), underflow=0; start-to-done = 1+4*(4+102+1+8+1+1)=469 cycles.
- Per-sensor r/s = (100,99), (100,70), (100,70), (100,95) -> diffs 1, 30, 30, 5; avg_diff=16 (66>>2), max_diff=30, max_idx=1 (tie keeps lower index), aged=1.
- Sensor 2 returns r=50, s=60, others r=s=100 -> underflow=1, diff 0; avg_diff=0, aged=0. Mode sequence checked as 01 -> 00 x4 -> 10 ... per sensor, with selects 0, 1, 2, 3 in order.
- rst asserted mid-MEAS of sensor 2 -> next cycle mode=00, busy=0, all results 0. A later start runs a full scan from idx=0. start pulsed while busy -> ignored, exactly one done.
- CDIR_SCAN_TIMEOUT_EN, TIMEOUT_CYCLES=64, valid_in never asserted for sensor 3 -> timeout_err=1, the scan completes, and avg is computed over 3 real diffs divided by 4. Without the macro the same stimulus -> busy stays 1 and done never pulses.
